// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, word width.
package md_unit_pkg;

  localparam int unsigned WORD = 32;

  // 3-bit MD op codes; codes 6 and 7 are unused and ignored by the unit.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

  // True for the four multi-cycle ops (mult/multu/div/divu).
  function automatic logic is_muldiv(input logic [2:0] code);
    return (code == MD_MULT) || (code == MD_MULTU) || (code == MD_DIV) || (code == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: runs mult/multu/div/divu with a fixed
// latency, handles mthi/mtlo, and owns the architectural HI/LO registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             clr,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] pend_hi_q, pend_lo_q;
  logic             pend_we_q;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, div_s, div_u, q_mag, r_mag;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic               nxt_we;
  logic [CntW-1:0]    nxt_cnt;
  logic               accept, finish;

  // Only an idle, un-flushed start of a mult/div op launches the FSM.
  assign accept = (state_q == StIdle) && start && !clr && is_muldiv(op);
  assign finish = (state_q == StBusy) && !clr && (cnt_q == '0);
  assign busy   = (state_q == StBusy);

  // Combinational result of the op presented on src_a/src_b this cycle.
  always_comb begin
    prod_s   = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    prod_u   = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    div_zero = (src_b == '0);
    a_neg    = src_a[WIDTH-1];
    b_neg    = src_b[WIDTH-1];
    // Signed divide through magnitudes so MIN / -1 wraps to MIN with zero remainder.
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    div_s    = div_zero ? WIDTH'(1) : b_mag;
    div_u    = div_zero ? WIDTH'(1) : src_b;
    q_mag    = a_mag / div_s;
    r_mag    = a_mag % div_s;
    nxt_hi   = '0;
    nxt_lo   = '0;
    nxt_we   = 1'b0;
    nxt_cnt  = CntW'(MULT_CYCLES - 1);
    case (op)
      MD_MULT: begin
        nxt_hi = prod_s[2*WIDTH-1:WIDTH];
        nxt_lo = prod_s[WIDTH-1:0];
        nxt_we = 1'b1;
      end
      MD_MULTU: begin
        nxt_hi = prod_u[2*WIDTH-1:WIDTH];
        nxt_lo = prod_u[WIDTH-1:0];
        nxt_we = 1'b1;
      end
      MD_DIV: begin
        nxt_lo  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        nxt_hi  = a_neg ? -r_mag : r_mag;
        nxt_we  = !div_zero;
        nxt_cnt = CntW'(DIV_CYCLES - 1);
      end
      MD_DIVU: begin
        nxt_lo  = src_a / div_u;
        nxt_hi  = src_a % div_u;
        nxt_we  = !div_zero;
        nxt_cnt = CntW'(DIV_CYCLES - 1);
      end
      default: ;
    endcase
  end

  // IDLE/BUSY FSM with the latency down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StBusy;
            cnt_q   <= nxt_cnt;
          end
        end
        StBusy: begin
          if (clr || (cnt_q == '0)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result captured at start so later operand changes cannot affect it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else if (accept) begin
      pend_hi_q <= nxt_hi;
      pend_lo_q <= nxt_lo;
      pend_we_q <= nxt_we;
    end
  end

  // Architectural HI/LO: commit at end of op, or direct mthi/mtlo writes while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (pend_we_q) begin
        hi <= pend_hi_q;
        lo <= pend_lo_q;
      end
    end else if ((state_q == StIdle) && start && !clr) begin
      if (op == MD_MTHI) hi <= src_a;
      if (op == MD_MTLO) lo <= src_a;
    end
  end

endmodule
